load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: consecutive BUSY cycles without bus_ready before abort; legal range 1..255.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 mem_read  in  1  execute-stage load request.
REQ-005 mem_write  in  1  execute-stage store request.
REQ-006 funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  in  32  byte address (ALU result).
REQ-008 store_data  in  32  rs2 value.
REQ-009 stall  out  1  holds the pipeline while an access is in flight.
REQ-010 mem_data  out  32  extended load result driven to the writeback select's memory input.
REQ-011 load_valid  out  1  one-cycle pulse when mem_data is updated.
REQ-012 fault  out  1  one-cycle pulse on a misaligned access or an unsupported funct3.
REQ-013 bus_error  out  1  one-cycle pulse on a timeout abort.
REQ-014 bus_req, bus_we  out  1 each  bus request and write enable.
REQ-015 bus_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-016 bus_wdata  out  32; bus_be  out  4  store data and byte enables.
REQ-017 bus_ready  in  1; bus_rdata  in  32  bus completion and read data.

Function
REQ-018 FSM states: IDLE, BUSY, DONE. bus_req SHALL equal (state==BUSY) and be decoded from registers only.
- IDLE: when mem_read or mem_write is high, latch addr, store_data, funct3 and type, and evaluate legality.
- If both requests are high, a store SHALL be performed and the read SHALL be ignored.
REQ-019 Illegal access: H with addr[0]=1, W with addr[1:0]!=0, or funct3 not listed (stores accept only 000/001/010).
- Response: fault pulses in the accept cycle; the FSM stays in IDLE; no bus_req; stall stays 0.
REQ-020 Legal accept: IDLE->BUSY. stall SHALL be 1 combinationally in the accept cycle and in every BUSY cycle, and 0 in DONE and idle IDLE.
REQ-021 BUSY: bus_addr, bus_we, bus_wdata and bus_be SHALL stay stable. The access completes in the first BUSY cycle with bus_ready=1, then BUSY->DONE.
REQ-022 Timeout: a counter increments on each BUSY cycle with bus_ready=0.
- On the TIMEOUT_CYCLES-th such cycle: bus_error pulses, mem_data is loaded with 0, load_valid pulses for loads, and the FSM goes BUSY->DONE.
- The counter clears on entry to BUSY.
REQ-023 DONE: always returns to IDLE after one cycle. Requests present during DONE belong to the completing instruction and SHALL be ignored.
REQ-024 Latency: stall high for 2+N cycles, where N is the number of BUSY cycles with bus_ready low.
REQ-025 Store data: B replicates store_data[7:0] x4; H replicates store_data[15:0] x2; W passes through.
REQ-026 Byte enables: bus_be = 4'b0001<<addr[1:0] (B), 4'b0011<<{addr[1],1'b0} (H), 4'b1111 (W). Loads SHALL drive bus_be=4'b1111 and bus_we=0.
REQ-027 Load path, on completion:
- Select the lane of bus_rdata using latched addr[1:0].
- Sign-extend for B/H; zero-extend for BU/HU.
- Register the result into mem_data and pulse load_valid in DONE.
REQ-028 mem_data SHALL hold its value across stores, faults and idle cycles.
REQ-029 bus_ready SHALL be ignored outside BUSY.

Reset
REQ-030 While rst_n is low, the block SHALL immediately (asynchronously):
- go to IDLE and clear the counter;
- set stall, bus_req, bus_we, load_valid, fault and bus_error to 0;
- set mem_data, bus_addr, bus_wdata and bus_be to 0.
REQ-031 Reset during BUSY SHALL abandon the access: bus_req drops without waiting for bus_ready, and no pulses follow.

Structure
REQ-032 Package lsu_pkg SHALL hold the funct3 encodings, the state enum and the TIMEOUT_CYCLES default.
REQ-033 Lane select and extension SHALL live in the combinational sub-module load_extend (rdata, byte offset, funct3 -> 32-bit result).

Verification
REQ-034 LW 0x100, bus_ready on the 3rd BUSY cycle, rdata 0xDEADBEEF -> mem_data=0xDEADBEEF, load_valid one cycle, stall 4 cycles.
REQ-035 LB 0x103, rdata 0x80123456 -> mem_data 0xFFFFFF80. LBU at the same address -> 0x00000080. LH 0x102 -> 0xFFFF8012.
REQ-036 SH 0x102, store_data 0x0000ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD, bus_addr=0x100; mem_data unchanged.
REQ-037 LW 0x101 or funct3=011 -> fault for one cycle, bus_req never high, stall 0.
REQ-038 TIMEOUT_CYCLES=4, bus_ready held 0 -> bus_error after 4 BUSY cycles, mem_data=0, back to IDLE.
REQ-039 rst_n low mid-BUSY -> bus_req and stall drop immediately; after release, a new LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings, FSM states, bus payload type and the legality helper for the load/store unit.
package lsu_pkg;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;
    localparam int unsigned CNT_W               = 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_req_t;

    // Stores accept only B/H/W; halfwords need even and words need 4-byte alignment.
    function automatic logic access_legal(input logic [2:0] f3, input logic [1:0] off,
                                          input logic is_store);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = ~is_store;
            F3_HU:   ok = ~is_store & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/halfword lane of a read word and sign- or zero-extends it.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        byte_c   = rdata_i[7:0];
        half_c   = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        result_o = rdata_i;
        case (off_i)
            2'd0:    byte_c = rdata_i[7:0];
            2'd1:    byte_c = rdata_i[15:8];
            2'd2:    byte_c = rdata_i[23:16];
            default: byte_c = rdata_i[31:24];
        endcase
        case (funct3_i)
            F3_B:    result_o = {{24{byte_c[7]}}, byte_c};
            F3_H:    result_o = {{16{half_c[15]}}, half_c};
            F3_BU:   result_o = {24'd0, byte_c};
            F3_HU:   result_o = {16'd0, half_c};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts an execute-stage access, runs it on a
// ready/valid-style bus with a timeout, and returns extended load data.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] mem_data,
    output logic        load_valid,
    output logic        fault,
    output logic        bus_error,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    bus_req_t           req_q, req_d;
    logic [2:0]         funct3_q;
    logic [1:0]         off_q;
    logic [31:0]        mem_data_q;
    logic               load_valid_q;
    logic               bus_error_q;

    logic               req_c;
    logic               legal_c;
    logic               accept_c;
    logic               timeout_c;
    logic [31:0]        ext_c;

    assign req_c     = mem_read | mem_write;
    assign legal_c   = access_legal(funct3, addr[1:0], mem_write);
    // Gated by rst_n so the combinational handshakes are quiet while reset is held.
    assign accept_c  = rst_n & (state_q == ST_IDLE) & req_c & legal_c;
    assign fault     = rst_n & (state_q == ST_IDLE) & req_c & ~legal_c;
    assign stall     = accept_c | (state_q == ST_BUSY);
    assign timeout_c = (state_q == ST_BUSY) & ~bus_ready
                     & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Build the bus payload; a write request wins over a simultaneous read.
    always_comb begin
        req_d      = '0;
        req_d.addr = {addr[31:2], 2'b00};
        req_d.we   = mem_write;
        req_d.be   = 4'b1111;
        if (mem_write) begin
            case (funct3)
                F3_B: begin
                    req_d.wdata = {4{store_data[7:0]}};
                    req_d.be    = 4'b0001 << addr[1:0];
                end
                F3_H: begin
                    req_d.wdata = {2{store_data[15:0]}};
                    req_d.be    = 4'b0011 << {addr[1], 1'b0};
                end
                default: req_d.wdata = store_data;
            endcase
        end
    end

    load_extend u_load_extend (
        .rdata_i  (bus_rdata),
        .off_i    (off_q),
        .funct3_i (funct3_q),
        .result_o (ext_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_q        <= '0;
            funct3_q     <= '0;
            off_q        <= '0;
            mem_data_q   <= '0;
            load_valid_q <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            load_valid_q <= 1'b0;
            bus_error_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        state_q  <= ST_BUSY;
                        cnt_q    <= '0;
                        req_q    <= req_d;
                        funct3_q <= funct3;
                        off_q    <= addr[1:0];
                    end
                end
                ST_BUSY: begin
                    if (bus_ready) begin
                        state_q <= ST_DONE;
                        if (!req_q.we) begin
                            mem_data_q   <= ext_c;
                            load_valid_q <= 1'b1;
                        end
                    end else if (timeout_c) begin
                        state_q     <= ST_DONE;
                        bus_error_q <= 1'b1;
                        if (!req_q.we) begin
                            mem_data_q   <= '0;
                            load_valid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus_req    = (state_q == ST_BUSY);
    assign bus_we     = req_q.we;
    assign bus_addr   = req_q.addr;
    assign bus_wdata  = req_q.wdata;
    assign bus_be     = req_q.be;
    assign mem_data   = mem_data_q;
    assign load_valid = load_valid_q;
    assign bus_error  = bus_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, faults, timeout and reset abort.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        stall, load_valid, fault, bus_error, bus_req, bus_we;
    logic [31:0] mem_data, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    int          acc_stall, stall_cycles, fault_cycles, busy_cycles, req_seen, lv_cnt, berr_cnt;
    logic        finished, unstable;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .stall      (stall),
        .mem_data   (mem_data),
        .load_valid (load_valid),
        .fault      (fault),
        .bus_error  (bus_error),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_be     (bus_be),
        .bus_ready  (bus_ready),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One access: present request for one cycle, answer bus_req after ready_after low cycles
    // (negative = never), and tally stall/pulse cycles until the unit is idle again.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] sd,
                             input int ready_after, input logic [31:0] rdata);
        @(negedge clk);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
        #1;
        acc_stall    = int'(stall);
        stall_cycles = int'(stall);
        fault_cycles = int'(fault);
        busy_cycles = 0; req_seen = 0; lv_cnt = 0; berr_cnt = 0;
        finished = 1'b0; unstable = 1'b0;
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (stall)      stall_cycles++;
            if (fault)      fault_cycles++;
            if (load_valid) lv_cnt++;
            if (bus_error)  berr_cnt++;
            if (bus_req) begin
                if (req_seen == 0) begin
                    cap_addr = bus_addr; cap_wdata = bus_wdata; cap_be = bus_be; cap_we = bus_we;
                end else if (bus_addr !== cap_addr || bus_wdata !== cap_wdata ||
                             bus_be !== cap_be || bus_we !== cap_we) begin
                    unstable = 1'b1;
                end
                req_seen++;
                bus_ready = (busy_cycles == ready_after);
                bus_rdata = bus_ready ? rdata : 32'h0;
                busy_cycles++;
            end else begin
                bus_ready = 1'b0;
            end
            if (!bus_req && !stall && i >= 2) begin
                finished = 1'b1;
                break;
            end
        end
        bus_ready = 1'b0;
        check("terminated", 32'(finished), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        addr = 32'h0; store_data = 32'h0; bus_ready = 1'b0; bus_rdata = 32'h0;
        #12;
        check("rst_stall",      32'(stall),      32'd0);
        check("rst_bus_req",    32'(bus_req),    32'd0);
        check("rst_bus_we",     32'(bus_we),     32'd0);
        check("rst_load_valid", 32'(load_valid), 32'd0);
        check("rst_fault",      32'(fault),      32'd0);
        check("rst_bus_error",  32'(bus_error),  32'd0);
        check("rst_mem_data",   mem_data,        32'h0);
        check("rst_bus_addr",   bus_addr,        32'h0);
        check("rst_bus_wdata",  bus_wdata,       32'h0);
        check("rst_bus_be",     32'(bus_be),     32'h0);
        @(negedge clk); rst_n = 1'b1;

        // LW 0x100, ready on third BUSY cycle
        do_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF);
        check("lw_acc_stall",  32'(acc_stall),    32'd1);
        check("lw_stall_cyc",  32'(stall_cycles), 32'd4);
        check("lw_busy_cyc",   32'(busy_cycles),  32'd3);
        check("lw_lv_cnt",     32'(lv_cnt),       32'd1);
        check("lw_berr_cnt",   32'(berr_cnt),     32'd0);
        check("lw_mem_data",   mem_data,          32'hDEADBEEF);
        check("lw_bus_addr",   cap_addr,          32'h100);
        check("lw_bus_be",     32'(cap_be),       32'hF);
        check("lw_bus_we",     32'(cap_we),       32'd0);
        check("lw_stable",     32'(unstable),     32'd0);

        do_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80123456);
        check("lb_mem_data",   mem_data,          32'hFFFFFF80);
        check("lb_stall_cyc",  32'(stall_cycles), 32'd2);
        do_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80123456);
        check("lbu_mem_data",  mem_data,          32'h00000080);
        do_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 0, 32'h80123456);
        check("lh_mem_data",   mem_data,          32'hFFFF8012);
        do_access(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 0, 32'h80123456);
        check("lhu_mem_data",  mem_data,          32'h00003456);
        do_access(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 0, 32'h80123456);
        check("lb1_mem_data",  mem_data,          32'h00000034);

        // SH 0x102, one wait cycle
        do_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 1, 32'h0);
        check("sh_bus_we",     32'(cap_we),       32'd1);
        check("sh_bus_be",     32'(cap_be),       32'hC);
        check("sh_bus_wdata",  cap_wdata,         32'hABCDABCD);
        check("sh_bus_addr",   cap_addr,          32'h100);
        check("sh_mem_data",   mem_data,          32'h00000034);
        check("sh_lv_cnt",     32'(lv_cnt),       32'd0);
        check("sh_stall_cyc",  32'(stall_cycles), 32'd3);
        check("sh_stable",     32'(unstable),     32'd0);

        // read and write together: store wins
        do_access(1'b1, 1'b1, 3'b000, 32'h101, 32'h12345678, 0, 32'hFFFFFFFF);
        check("rw_bus_we",     32'(cap_we),       32'd1);
        check("rw_bus_be",     32'(cap_be),       32'h2);
        check("rw_bus_wdata",  cap_wdata,         32'h78787878);
        check("rw_lv_cnt",     32'(lv_cnt),       32'd0);
        check("rw_mem_data",   mem_data,          32'h00000034);

        do_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h0);
        check("misw_fault_cyc", 32'(fault_cycles), 32'd1);
        check("misw_req_seen",  32'(req_seen),     32'd0);
        check("misw_stall_cyc", 32'(stall_cycles), 32'd0);
        check("misw_mem_data",  mem_data,          32'h00000034);
        do_access(1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 0, 32'h0);
        check("f3_fault_cyc",   32'(fault_cycles), 32'd1);
        check("f3_req_seen",    32'(req_seen),     32'd0);
        do_access(1'b0, 1'b1, 3'b100, 32'h0, 32'h0, 0, 32'h0);
        check("sbu_fault_cyc",  32'(fault_cycles), 32'd1);
        check("sbu_req_seen",   32'(req_seen),     32'd0);
        do_access(1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 0, 32'h0);
        check("mish_fault_cyc", 32'(fault_cycles), 32'd1);

        // bus_ready while idle has no effect
        @(negedge clk); bus_ready = 1'b1; bus_rdata = 32'h55555555;
        repeat (3) @(negedge clk);
        check("idle_rdy_req",  32'(bus_req),      32'd0);
        check("idle_rdy_lv",   32'(load_valid),   32'd0);
        check("idle_rdy_md",   mem_data,          32'h00000034);
        bus_ready = 1'b0; bus_rdata = 32'h0;

        // timeout after 4 BUSY cycles
        do_access(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, -1, 32'h0);
        check("to_busy_cyc",   32'(busy_cycles),  32'd4);
        check("to_berr_cnt",   32'(berr_cnt),     32'd1);
        check("to_lv_cnt",     32'(lv_cnt),       32'd1);
        check("to_mem_data",   mem_data,          32'h0);
        check("to_stall_cyc",  32'(stall_cycles), 32'd5);
        check("to_idle_req",   32'(bus_req),      32'd0);

        // reset in the middle of BUSY abandons the access
        do_access(1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 0, 32'h000000AA);
        @(negedge clk); mem_read = 1'b1; funct3 = 3'b010; addr = 32'h300;
        @(posedge clk); #1; mem_read = 1'b0;
        @(negedge clk);
        check("mid_bus_req",   32'(bus_req),      32'd1);
        #2; rst_n = 1'b0; #1;
        check("rst_mid_req",   32'(bus_req),      32'd0);
        check("rst_mid_stall", 32'(stall),        32'd0);
        check("rst_mid_md",    mem_data,          32'h0);
        @(negedge clk); rst_n = 1'b1;
        lv_cnt = 0; berr_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (load_valid || bus_error || bus_req) lv_cnt++;
        end
        check("post_rst_quiet", 32'(lv_cnt),      32'd0);
        do_access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 1, 32'h0BADF00D);
        check("post_lw_md",    mem_data,          32'h0BADF00D);
        check("post_lw_stall", 32'(stall_cycles), 32'd3);
        check("post_lw_addr",  cap_addr,          32'h104);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
